// File: rtl/fp_mul_pkg.sv
// Shared types for the iterative floating-point multiplier.
package fp_mul_pkg;

  // Sequencer states of the multiplier.
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_UNPACK,
    ST_MULT,
    ST_NORM,
    ST_ROUND,
    ST_DONE
  } state_t;

  // Operand classes; subnormal inputs are classified as zero (flush-to-zero).
  typedef enum logic [1:0] {
    FC_ZERO,
    FC_NORM,
    FC_INF,
    FC_NAN
  } fclass_t;

endpackage

// File: rtl/fp_classify.sv
// Combinational operand classifier: class, sign, biased exponent, significand.
module fp_classify
  import fp_mul_pkg::*;
#(
  parameter int unsigned EXP_W = 8,
  parameter int unsigned MAN_W = 23
) (
  input  logic [EXP_W+MAN_W:0] op,
  output fclass_t              fclass_c,
  output logic                 sign_c,
  output logic [EXP_W-1:0]     exp_c,
  output logic [MAN_W:0]       sig_c
);

  // Split the word and classify from the exponent/fraction fields.
  always_comb begin
    sign_c   = op[EXP_W+MAN_W];
    exp_c    = op[EXP_W+MAN_W-1 -: EXP_W];
    sig_c    = {1'b1, op[MAN_W-1:0]};
    fclass_c = FC_NORM;
    if (exp_c == '0) begin
      fclass_c = FC_ZERO;
    end else if (&exp_c) begin
      fclass_c = (op[MAN_W-1:0] == '0) ? FC_INF : FC_NAN;
    end
  end

endmodule

// File: rtl/fp_mul_iter.sv
// Iterative IEEE-754-style multiplier: shift-add significand product, RNE,
// flush-to-zero, start/busy/done handshake.
module fp_mul_iter
  import fp_mul_pkg::*;
#(
  parameter int unsigned EXP_W = 8,
  parameter int unsigned MAN_W = 23
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   mul_start,
  input  logic [EXP_W+MAN_W:0]   op1,
  input  logic [EXP_W+MAN_W:0]   op2,
  output logic                   mul_busy,
  output logic                   mul_done,
  output logic [EXP_W+MAN_W:0]   mul_result,
  output logic                   mul_overflow,
  output logic                   mul_underflow,
  output logic                   mul_invalid
);

  localparam int unsigned W     = 1 + EXP_W + MAN_W;
  localparam int unsigned N     = MAN_W + 1;
  localparam int unsigned CNT_W = $clog2(MAN_W + 2);
  localparam int unsigned EW    = EXP_W + 2;
  localparam logic signed [EW-1:0] BIAS_S = EW'((2 ** (EXP_W - 1)) - 1);
  localparam logic signed [EW-1:0] EMAX_S = EW'((2 ** EXP_W) - 1);
  localparam logic signed [EW-1:0] ZERO_S = '0;
  localparam logic signed [EW-1:0] ONE_S  = EW'(1);
  localparam logic [W-1:0] QNAN = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};

  state_t                 state, state_n;
  logic [W-1:0]           op1_q, op2_q;
  logic [2*N-1:0]         prod;
  logic [N-1:0]           mplr;
  logic [CNT_W-1:0]       cnt;
  logic signed [EW-1:0]   exp_q;
  logic                   sign_q;
  logic                   sticky_q;

  fclass_t                cls1, cls2;
  logic                   s1, s2;
  logic [EXP_W-1:0]       e1, e2;
  logic [MAN_W:0]         sig1, sig2;

  fp_classify #(.EXP_W(EXP_W), .MAN_W(MAN_W)) u_cls1 (
    .op(op1_q), .fclass_c(cls1), .sign_c(s1), .exp_c(e1), .sig_c(sig1)
  );
  fp_classify #(.EXP_W(EXP_W), .MAN_W(MAN_W)) u_cls2 (
    .op(op2_q), .fclass_c(cls2), .sign_c(s2), .exp_c(e2), .sig_c(sig2)
  );

  logic                   special_c, invalid_c;
  logic [W-1:0]           spec_res_c;
  logic signed [EW-1:0]   exp_sum_c;

  // Special-operand decode and the unbiased-sum exponent.
  always_comb begin
    special_c  = (cls1 != FC_NORM) || (cls2 != FC_NORM);
    invalid_c  = ((cls1 == FC_INF) && (cls2 == FC_ZERO)) ||
                 ((cls1 == FC_ZERO) && (cls2 == FC_INF));
    spec_res_c = {s1 ^ s2, {(W-1){1'b0}}};
    if ((cls1 == FC_NAN) || (cls2 == FC_NAN) || invalid_c) begin
      spec_res_c = QNAN;
    end else if ((cls1 == FC_INF) || (cls2 == FC_INF)) begin
      spec_res_c = {s1 ^ s2, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
    end
    exp_sum_c = $signed(EW'(e1)) + $signed(EW'(e2)) - BIAS_S;
  end

  logic                   step_bit_c;
  logic [N-1:0]           addend_c;
  logic [N:0]             sum_c;
  logic [2*N-1:0]         prod_step_c;

  // One shift-add step; the first step runs during UNPACK on the fresh multiplier.
  always_comb begin
    step_bit_c  = (state == ST_UNPACK) ? sig2[0] : mplr[0];
    addend_c    = step_bit_c ? sig1 : '0;
    sum_c       = (N+1)'(prod[2*N-1:N]) + (N+1)'(addend_c);
    prod_step_c = {sum_c, prod[N-1:1]};
  end

  logic [N-1:0]           mant_c;
  logic [MAN_W-2:0]       low_shl_c;
  logic                   inc_c;
  logic [N:0]             mant_r_c;
  logic [MAN_W-1:0]       frac_r_c;
  logic signed [EW-1:0]   exp_r_c;
  logic                   ovf_c, unf_c;

  // Round-to-nearest-even on the normalised product and range check.
  always_comb begin
    mant_c    = prod[2*MAN_W -: N];
    low_shl_c = prod[MAN_W-2:0] << 1;
    inc_c     = prod[MAN_W-1] &
                (prod[MAN_W-2] | sticky_q | (|low_shl_c) | mant_c[0]);
    mant_r_c  = (N+1)'(mant_c) + (N+1)'(inc_c);
    frac_r_c  = mant_r_c[N] ? mant_r_c[MAN_W:1] : mant_r_c[MAN_W-1:0];
    exp_r_c   = exp_q + $signed(EW'(mant_r_c[N]));
    ovf_c     = exp_r_c >= EMAX_S;
    unf_c     = exp_r_c <= ZERO_S;
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_n;
  end

  // Next-state logic.
  always_comb begin
    state_n = state;
    case (state)
      ST_IDLE:   if (mul_start) state_n = ST_UNPACK;
      ST_UNPACK: state_n = special_c ? ST_DONE : ST_MULT;
      ST_MULT:   if (cnt == CNT_W'(MAN_W - 1)) state_n = ST_NORM;
      ST_NORM:   state_n = ST_ROUND;
      ST_ROUND:  state_n = ST_DONE;
      ST_DONE:   state_n = ST_IDLE;
      default:   state_n = ST_IDLE;
    endcase
  end

  // Datapath registers and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      op1_q         <= '0;
      op2_q         <= '0;
      prod          <= '0;
      mplr          <= '0;
      cnt           <= '0;
      exp_q         <= '0;
      sign_q        <= 1'b0;
      sticky_q      <= 1'b0;
      mul_busy      <= 1'b0;
      mul_done      <= 1'b0;
      mul_result    <= '0;
      mul_overflow  <= 1'b0;
      mul_underflow <= 1'b0;
      mul_invalid   <= 1'b0;
    end else begin
      mul_busy <= (state_n != ST_IDLE);
      mul_done <= (state_n == ST_DONE);
      case (state)
        ST_IDLE: begin
          if (mul_start) begin
            op1_q <= op1;
            op2_q <= op2;
            prod  <= '0;
          end
        end
        ST_UNPACK: begin
          prod     <= prod_step_c;
          mplr     <= sig2 >> 1;
          cnt      <= '0;
          exp_q    <= exp_sum_c;
          sign_q   <= s1 ^ s2;
          sticky_q <= 1'b0;
          if (special_c) begin
            mul_result    <= spec_res_c;
            mul_overflow  <= 1'b0;
            mul_underflow <= 1'b0;
            mul_invalid   <= invalid_c;
          end
        end
        ST_MULT: begin
          prod <= prod_step_c;
          mplr <= mplr >> 1;
          cnt  <= cnt + CNT_W'(1);
        end
        ST_NORM: begin
          if (prod[2*N-1]) begin
            prod     <= prod >> 1;
            sticky_q <= prod[0];
            exp_q    <= exp_q + ONE_S;
          end
        end
        ST_ROUND: begin
          mul_overflow  <= ovf_c;
          mul_underflow <= !ovf_c && unf_c;
          mul_invalid   <= 1'b0;
          if (ovf_c)      mul_result <= {sign_q, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
          else if (unf_c) mul_result <= {sign_q, {(W-1){1'b0}}};
          else            mul_result <= {sign_q, exp_r_c[EXP_W-1:0], frac_r_c};
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fp_mul_iter.sv
// Bench for fp_mul_iter: single- and half-precision instances against an
// integer-arithmetic reference model plus literal expected values.
module tb_fp_mul_iter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        start_f, start_h;
  logic [31:0] a_f, b_f;
  logic [15:0] a_h, b_h;
  logic        busy_f, done_f, ovf_f, unf_f, inv_f;
  logic        busy_h, done_h, ovf_h, unf_h, inv_h;
  logic [31:0] res_f;
  logic [15:0] res_h;

  fp_mul_iter #(.EXP_W(8), .MAN_W(23)) dut_f (
    .clk(clk), .rst(rst), .mul_start(start_f), .op1(a_f), .op2(b_f),
    .mul_busy(busy_f), .mul_done(done_f), .mul_result(res_f),
    .mul_overflow(ovf_f), .mul_underflow(unf_f), .mul_invalid(inv_f)
  );

  fp_mul_iter #(.EXP_W(5), .MAN_W(10)) dut_h (
    .clk(clk), .rst(rst), .mul_start(start_h), .op1(a_h), .op2(b_h),
    .mul_busy(busy_h), .mul_done(done_h), .mul_result(res_h),
    .mul_overflow(ovf_h), .mul_underflow(unf_h), .mul_invalid(inv_h)
  );

  typedef struct {
    logic [34:0] model;
    logic [34:0] lit;
    logic        has_lit;
    int          t_done;
  } exp_t;

  exp_t q_f[$];
  exp_t q_h[$];
  int   blo_f = 0, bhi_f = -1, blo_h = 0, bhi_h = -1;
  int   errors = 0, checks = 0;
  int   cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic void check(string nm, logic [63:0] act, logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", nm, act, req, cyc);
    end
  endfunction

  // Reference: exact integer product, rounded by remainder-vs-half comparison.
  // Returns {overflow, underflow, invalid, result}.
  function automatic logic [34:0] model(int ew, int mw, logic [31:0] x, logic [31:0] y);
    longint unsigned emax, ex, ey, fx, fy, p, keep, rem, half, sgn, res;
    int  e, sh, bias;
    logic nx, ny, ix, iy, zx, zy, s, ovf, unf, inv;
    emax = (64'd1 << ew) - 1;
    bias = (1 << (ew - 1)) - 1;
    ex = (64'(x) >> mw) & emax;
    ey = (64'(y) >> mw) & emax;
    fx = 64'(x) & ((64'd1 << mw) - 1);
    fy = 64'(y) & ((64'd1 << mw) - 1);
    s  = x[ew+mw] ^ y[ew+mw];
    nx = (ex == emax) && (fx != 0);
    ny = (ey == emax) && (fy != 0);
    ix = (ex == emax) && (fx == 0);
    iy = (ey == emax) && (fy == 0);
    zx = (ex == 0);
    zy = (ey == 0);
    sgn = 64'(s) << (ew + mw);
    ovf = 0; unf = 0; inv = 0;
    if (nx || ny || (ix && zy) || (zx && iy)) begin
      res = (emax << mw) | (64'd1 << (mw - 1));
      inv = !(nx || ny);
    end else if (ix || iy) begin
      res = sgn | (emax << mw);
    end else if (zx || zy) begin
      res = sgn;
    end else begin
      p  = ((64'd1 << mw) | fx) * ((64'd1 << mw) | fy);
      e  = int'(ex) + int'(ey) - bias;
      sh = mw;
      if ((p >> (2 * mw + 1)) != 0) begin
        sh = mw + 1;
        e++;
      end
      keep = p >> sh;
      rem  = p & ((64'd1 << sh) - 1);
      half = 64'd1 << (sh - 1);
      if (rem > half || (rem == half && keep[0])) keep++;
      if (keep == (64'd1 << (mw + 1))) begin
        keep = keep >> 1;
        e++;
      end
      if (e >= int'(emax)) begin
        res = sgn | (emax << mw);
        ovf = 1;
      end else if (e <= 0) begin
        res = sgn;
        unf = 1;
      end else begin
        res = sgn | (64'(e) << mw) | (keep & ((64'd1 << mw) - 1));
      end
    end
    return {ovf, unf, inv, res[31:0]};
  endfunction

  function automatic bit is_special(int ew, int mw, logic [31:0] x, logic [31:0] y);
    longint unsigned emax, ex, ey;
    emax = (64'd1 << ew) - 1;
    ex = (64'(x) >> mw) & emax;
    ey = (64'(y) >> mw) & emax;
    return (ex == 0) || (ey == 0) || (ex == emax) || (ey == emax);
  endfunction

  // Compare process: busy window every cycle, result/flags/latency on done.
  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      check("busy_f", 64'(busy_f), 64'(cyc >= blo_f && cyc <= bhi_f));
      check("busy_h", 64'(busy_h), 64'(cyc >= blo_h && cyc <= bhi_h));
      if (done_f) begin
        if (q_f.size() == 0) check("extra_done_f", 64'(done_f), 64'(0));
        else begin
          e = q_f.pop_front();
          check("model_f", 64'({ovf_f, unf_f, inv_f, res_f}), 64'(e.model));
          check("latency_f", 64'(cyc), 64'(e.t_done));
          if (e.has_lit) check("literal_f", 64'({ovf_f, unf_f, inv_f, res_f}), 64'(e.lit));
        end
      end else if (q_f.size() != 0 && cyc > q_f[0].t_done) begin
        check("late_done_f", 64'(done_f), 64'(1));
        void'(q_f.pop_front());
      end
      if (done_h) begin
        if (q_h.size() == 0) check("extra_done_h", 64'(done_h), 64'(0));
        else begin
          e = q_h.pop_front();
          check("model_h", 64'({ovf_h, unf_h, inv_h, 16'h0, res_h}), 64'(e.model));
          check("latency_h", 64'(cyc), 64'(e.t_done));
          if (e.has_lit) check("literal_h", 64'({ovf_h, unf_h, inv_h, 16'h0, res_h}), 64'(e.lit));
        end
      end else if (q_h.size() != 0 && cyc > q_h[0].t_done) begin
        check("late_done_h", 64'(done_h), 64'(1));
        void'(q_h.pop_front());
      end
    end
  end

  // Issue one operation on the chosen instance; optionally wait for completion.
  task automatic issue(input bit h, input logic [31:0] a, input logic [31:0] b,
                       input logic [34:0] lit, input bit has_lit, input bit wait_done);
    exp_t e;
    int   n, t, lat, ew, mw;
    ew = h ? 5 : 8;
    mw = h ? 10 : 23;
    n = 0;
    @(negedge clk);
    while ((h ? busy_h : busy_f) && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (h) begin a_h = a[15:0]; b_h = b[15:0]; start_h = 1'b1; end
    else   begin a_f = a;       b_f = b;       start_f = 1'b1; end
    @(posedge clk);
    #1;
    t = cyc;
    start_f = 1'b0;
    start_h = 1'b0;
    a_f = $urandom;
    b_f = $urandom;
    a_h = 16'($urandom);
    b_h = 16'($urandom);
    lat = is_special(ew, mw, a, b) ? 2 : mw + 4;
    e.model   = model(ew, mw, a, b);
    e.lit     = lit;
    e.has_lit = has_lit;
    e.t_done  = t + lat - 1;
    if (h) begin q_h.push_back(e); blo_h = t; bhi_h = t + lat - 1; end
    else   begin q_f.push_back(e); blo_f = t; bhi_f = t + lat - 1; end
    if (wait_done) wait_idle();
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((q_f.size() != 0 || q_h.size() != 0) && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (q_f.size() != 0 || q_h.size() != 0) begin
      check("timeout_pending", 64'(q_f.size() + q_h.size()), 64'(0));
      q_f.delete();
      q_h.delete();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; start_f = 1'b0; start_h = 1'b0;
    a_f = '0; b_f = '0; a_h = '0; b_h = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("reset_f", 64'({busy_f, done_f, ovf_f, unf_f, inv_f, res_f}), 64'(0));
    check("reset_h", 64'({busy_h, done_h, ovf_h, unf_h, inv_h, res_h}), 64'(0));

    // Basic products.
    issue(0, 32'h3FA00000, 32'h3FC00000, {3'b000, 32'h3FF00000}, 1, 1);
    issue(0, 32'h3F800000, 32'hC0C00000, {3'b000, 32'hC0C00000}, 1, 1);
    issue(0, 32'hC0400000, 32'hC0800000, {3'b000, 32'h41400000}, 1, 1);
    // Rounding.
    issue(0, 32'h3F800001, 32'h3F800001, {3'b000, 32'h3F800002}, 1, 1);
    issue(0, 32'h3F800800, 32'h3F800800, {3'b000, 32'h3F801000}, 1, 1);
    issue(0, 32'h3FFFFFFF, 32'h3FFFFFFF, {3'b000, 32'h407FFFFE}, 1, 1);
    // Specials.
    issue(0, 32'h7F800000, 32'h00000000, {3'b001, 32'h7FC00000}, 1, 1);
    issue(0, 32'hFF800000, 32'h40000000, {3'b000, 32'hFF800000}, 1, 1);
    issue(0, 32'h00000001, 32'h3F800000, {3'b000, 32'h00000000}, 1, 1);
    issue(0, 32'h7FC00001, 32'h3F800000, {3'b000, 32'h7FC00000}, 1, 1);
    issue(0, 32'h80000000, 32'h3F800000, {3'b000, 32'h80000000}, 1, 1);
    // Exponent range.
    issue(0, 32'h7F000000, 32'h40000000, {3'b100, 32'h7F800000}, 1, 1);
    issue(0, 32'h00800000, 32'h3F000000, {3'b010, 32'h00000000}, 1, 1);
    // Model-only products, including round-up with significand carry.
    issue(0, 32'h3FFFFFFF, 32'h3F800001, '0, 0, 1);
    issue(0, 32'h3FAAAAAB, 32'h40490FDB, '0, 0, 1);
    issue(0, 32'h7F7FFFFF, 32'h3F800001, '0, 0, 1);
    issue(0, 32'h00FFFFFF, 32'h3F7FFFFF, '0, 0, 1);

    // Start pulse with new operands mid-operation is ignored.
    issue(0, 32'h40400000, 32'h40A00000, {3'b000, 32'h41700000}, 1, 0);
    repeat (4) @(negedge clk);
    a_f = 32'h3F800000; b_f = 32'h3F800000; start_f = 1'b1;
    @(negedge clk);
    start_f = 1'b0;
    wait_idle();
    repeat (5) @(negedge clk);

    // Reset mid-operation aborts it.
    issue(0, 32'h40400000, 32'h40400000, '0, 0, 0);
    repeat (9) @(negedge clk);
    rst = 1'b1;
    q_f.delete();
    blo_f = 0; bhi_f = -1;
    @(negedge clk);
    rst = 1'b0;
    check("abort_outputs", 64'({busy_f, done_f, ovf_f, unf_f, inv_f, res_f}), 64'(0));
    repeat (40) @(negedge clk);
    issue(0, 32'h40400000, 32'h40400000, {3'b000, 32'h41100000}, 1, 1);

    // Half precision instance.
    issue(1, 32'h3E00, 32'h4200, {3'b000, 32'h00004480}, 1, 1);
    issue(1, 32'h7BFF, 32'h4000, {3'b100, 32'h00007C00}, 1, 1);
    issue(1, 32'hFC00, 32'h0000, {3'b001, 32'h00007E00}, 1, 1);
    issue(1, 32'h3C01, 32'h3BFF, '0, 0, 1);
    issue(1, 32'h0400, 32'h3800, {3'b010, 32'h00000000}, 1, 1);

    repeat (5) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
